// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  // Decimal digits of 2^bin_w-1, i.e. ceil(bin_w*log10(2)).
  // No power of ten falls between 2^n-1 and 2^n, so the ceiling is exact.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble add-3 cell: a digit of 5..9 becomes 8..12 so the next shift carries.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ : d;

endmodule

// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble converter, one input bit per clock, valid/ready on both sides.
// Reports sign, overflow (truncation to DIGITS) and a leading-zero significance mask.
module seq_bin2bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic [DIGITS-1:0]     sig_mask
);

  localparam int DW      = DIGITS * 4;
  localparam int CW      = $clog2(BIN_W);
  localparam bit IS_SGN  = (SIGNED != 0);
  localparam bit CAN_OVF = (DIGITS < min_digits(BIN_W));

  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic [BIN_W-1:0]  sr;
  logic [DW-1:0]     acc, acc_adj, acc_nxt;
  logic              ovf_acc, neg_acc;
  logic [DIGITS-1:0] mask_nxt;
  logic              accept, last, in_neg, shout;
  logic [BIN_W-1:0]  mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (acc[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  assign accept  = in_valid && in_ready;
  assign last    = (state == SHIFT) && (cnt == '0);
  assign in_neg  = IS_SGN && bin[BIN_W-1];
  // Two's-complement negate; the most-negative code maps to 2^(BIN_W-1), still fits unsigned.
  assign mag     = in_neg ? (~bin + BIN_W'(1)) : bin;
  assign acc_nxt = {acc_adj[DW-2:0], sr[BIN_W-1]};
  assign shout   = CAN_OVF && acc_adj[DW-1];

  // A digit is significant if it or any higher digit is nonzero; ones digit always shown.
  always_comb begin
    logic any;
    any      = 1'b0;
    mask_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any         = any | (|acc_nxt[4*i +: 4]);
      mask_nxt[i] = any;
    end
    mask_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)   nxt = SHIFT;
      SHIFT:   if (cnt == '0)  nxt = DONE;
      DONE:    if (out_ready)  nxt = IDLE;
      default:                 nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sr       <= '0;
      acc      <= '0;
      ovf_acc  <= 1'b0;
      neg_acc  <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      sig_mask <= DIGITS'(1);
    end else if (accept) begin
      cnt     <= CW'(BIN_W - 1);
      sr      <= mag;
      acc     <= '0;
      ovf_acc <= 1'b0;
      neg_acc <= in_neg;
    end else if (state == SHIFT) begin
      cnt     <= cnt - CW'(1);
      sr      <= {sr[BIN_W-2:0], 1'b0};
      acc     <= acc_nxt;
      ovf_acc <= ovf_acc | shout;
      // Visible results only change on completion, so a consumer never sees a partial value.
      if (last) begin
        bcd      <= acc_nxt;
        neg      <= neg_acc;
        ovf      <= ovf_acc | shout;
        sig_mask <= mask_nxt;
      end
    end
  end

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
- Iterative, clocked double-dabble converter from a BIN_W-bit binary word to DIGITS packed BCD digits.
- Handles one input bit per clock and uses valid/ready handshakes on both sides.
- Optionally accepts two's-complement input. Flags overflow when DIGITS is too small.
- Outputs a leading-zero significance mask, so the 7-segment display path can blank leading digits on score, guess and counter readouts.

Parameters:
BIN_W, 8, width of binary input (>=2)
DIGITS, 3, number of BCD output digits (>=1)
SIGNED, 0, 1 = input treated as two's complement; magnitude converted, sign reported on neg

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bin is valid
in_ready  output  1  converter idle, can accept
bin  input  BIN_W  binary value, sampled only on accept
out_valid  output  1  bcd/neg/ovf/sig_mask valid
out_ready  input  1  consumer accepts result
bcd  output  DIGITS*4  digit i at [4i+3:4i], digit 0 = ones
neg  output  1  input was negative (always 0 when SIGNED=0)
ovf  output  1  magnitude > 10^DIGITS-1; bcd then holds magnitude mod 10^DIGITS
sig_mask  output  DIGITS  bit i=1 if digit i is significant (nonzero or any higher digit nonzero); bit 0 always 1

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; in_ready=1; out_valid=0; bcd=0; neg=0; ovf=0; sig_mask=1 (bit 0 only); bit counter=0; shift register=0.
- Reset mid-operation: aborts any conversion immediately. No partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on an edge with in_valid&&in_ready:
  - capture the magnitude into the shift register: bin, or -bin when SIGNED=1 and bin[BIN_W-1]=1;
  - capture neg; clear the digit accumulator and ovf; load counter=BIN_W-1; go to SHIFT.
  - The most-negative input (e.g. 8'h80) has magnitude 2^(BIN_W-1), which fits unsigned.
- SHIFT, each edge:
  - every digit >=5 gets +3 (all digits adjusted in parallel from the current values);
  - then the {digits, shift reg} concatenation shifts left 1, taking the MSB of the shift register into digit 0 bit 0;
  - the bit shifted out of the top digit's bit 3 ORs into sticky ovf;
  - the counter decrements. When counter==0 on this edge, go to DONE and register sig_mask from the final digits.
- Latency: exactly BIN_W edges from the accept edge to the edge on which out_valid rises.
- DONE: outputs stable while out_valid=1 && out_ready=0, for any duration. On an edge with out_ready=1, go to IDLE.
  - bcd, neg, ovf and sig_mask hold their last values until the next conversion completes; they are valid only while out_valid=1.
- Throughput: one conversion per BIN_W+2 cycles minimum. Accept and complete never overlap.
- in_valid while busy: ignored, no queuing. Changes on bin after accept: ignored.
- Width rules:
  - digit adders are 4 bits wide with no carry out; the adjust value is only ever added to digits 5..9, giving 8..12, so no wrap;
  - counter width is $clog2(BIN_W).
- DIGITS: values below ceil(BIN_W*log10(2)) are legal; ovf then signals truncation.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - constants BCD_ADJ_THRESH=5 and BCD_ADJ=3;
  - function min_digits(bin_w), returning the digit count needed for no overflow.
- Sub-module bcd_digit_adjust: combinational, one 4-bit digit in, adjusted digit out (+3 if >=5), instantiated DIGITS times via generate.
- FSM, counter, shift register and flag logic live in seq_bin2bcd.

Test Plan:
1. BIN_W=8, DIGITS=3: accept bin=255 -> out_valid exactly 8 edges after accept; bcd=12'h255, ovf=0, neg=0, sig_mask=3'b111.
2. bin=0, then bin=7, back-to-back with out_ready=1 -> bcd=000, sig_mask=3'b001; then bcd=007, sig_mask=3'b001. in_ready stays low from accept until the cycle after the DONE handshake.
3. BIN_W=8, DIGITS=2: bin=255 -> bcd=8'h55, ovf=1. Then bin=99 -> bcd=8'h99, ovf=0 (sticky flag clears per conversion).
4. SIGNED=1, BIN_W=8, DIGITS=3:
   - bin=8'h80 -> neg=1, bcd=12'h128;
   - bin=8'hFF -> neg=1, bcd=12'h001;
   - bin=8'h7F -> neg=0, bcd=12'h127.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggle in_valid/bin meanwhile -> outputs constant, in_ready=0, no new accept. Release -> IDLE next cycle.
6. Reset: assert rst_n=0 asynchronously after 3 SHIFT edges with bin=200 -> outputs at reset values immediately, in_ready=1. After release, bin=42 converts cleanly to 12'h042.
